// File: rtl/execute_mem_stage.sv
// Execute/memory stage: one-hot ALU, single-outstanding load/store on a req/ack bus,
// and the registered writeback triple for the register file.
module execute_mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rd_ptr_i,
   input  logic [7:0]  funct3I_i,
   input  logic [6:0]  funct7_i,
   input  logic        alu_src_i,
   input  logic        reg_we_i,
   input  logic        mem_we_i,
   input  logic        mem_re_i,
   input  logic [1:0]  hb_i,
   input  logic        ul_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        mem_wr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] rd_o,
   output logic [4:0]  rd_ptr_o,
   output logic        reg_we_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        wr_q, wr_d;
   logic [1:0]  hb_q, hb_d;
   logic        ul_q, ul_d;
   logic [4:0]  ld_ptr_q, ld_ptr_d;
   logic        ld_we_q, ld_we_d;
   logic [31:0] rd_q, rd_d;
   logic [4:0]  rd_ptr_q, rd_ptr_d;
   logic        reg_we_q, reg_we_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic [31:0] op2;
   logic [31:0] sum;
   logic [4:0]  shamt;
   logic [31:0] alu_res;

   assign op2   = alu_src_i ? imm_i : rs2_i;
   assign sum   = rs1_i + op2;
   assign shamt = op2[4:0];

   always_comb begin
      alu_res = '0;
      unique case (funct3I_i)
         8'h01:   alu_res = funct7_i[5] ? (rs1_i - op2) : sum;
         8'h02:   alu_res = rs1_i << shamt;
         8'h04:   alu_res = {31'd0, $signed(rs1_i) < $signed(op2)};
         8'h08:   alu_res = {31'd0, rs1_i < op2};
         8'h10:   alu_res = rs1_i ^ op2;
         8'h20:   alu_res = funct7_i[5] ? 32'($signed(rs1_i) >>> shamt) : (rs1_i >> shamt);
         8'h40:   alu_res = rs1_i | op2;
         8'h80:   alu_res = rs1_i & op2;
         default: alu_res = '0;
      endcase
   end

   // Access decode for the instruction presented in IDLE; hb=11 behaves as word.
   logic       mem_op;
   logic       is_byte;
   logic       is_half;
   logic       misaligned;
   logic [3:0] be_new;
   logic [31:0] wdata_new;

   assign mem_op     = mem_we_i | mem_re_i;
   assign is_byte    = (hb_i == 2'b00);
   assign is_half    = (hb_i == 2'b01);
   assign misaligned = (is_half & sum[0]) | (~is_byte & ~is_half & (sum[1:0] != 2'b00));

   always_comb begin
      if (is_byte) begin
         be_new    = 4'b0001 << sum[1:0];
         wdata_new = {4{rs2_i[7:0]}};
      end else if (is_half) begin
         be_new    = 4'b0011 << sum[1:0];
         wdata_new = {2{rs2_i[15:0]}};
      end else begin
         be_new    = 4'b1111;
         wdata_new = rs2_i;
      end
   end

   // Load lane extraction uses the registered address/size of the outstanding access.
   logic [31:0] rdata_sh;
   logic [15:0] half_v;
   logic [31:0] load_val;

   assign rdata_sh = mem_rdata_i >> {addr_q[1:0], 3'b000};
   assign half_v   = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

   always_comb begin
      if (hb_q == 2'b00) begin
         load_val = ul_q ? {24'd0, rdata_sh[7:0]} : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end else if (hb_q == 2'b01) begin
         load_val = ul_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      end else begin
         load_val = mem_rdata_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      wr_d       = wr_q;
      hb_d       = hb_q;
      ul_d       = ul_q;
      ld_ptr_d   = ld_ptr_q;
      ld_we_d    = ld_we_q;
      rd_d       = rd_q;
      rd_ptr_d   = rd_ptr_q;
      reg_we_d   = 1'b0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      stall_o    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (mem_op) begin
               if (misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  stall_o  = 1'b1;
                  state_d  = StWait;
                  addr_d   = sum;
                  wdata_d  = wdata_new;
                  be_d     = be_new;
                  wr_d     = mem_we_i;
                  hb_d     = hb_i;
                  ul_d     = ul_i;
                  ld_ptr_d = rd_ptr_i;
                  ld_we_d  = reg_we_i & (rd_ptr_i != 5'd0);
               end
            end else begin
               rd_d     = alu_res;
               rd_ptr_d = rd_ptr_i;
               reg_we_d = reg_we_i & (rd_ptr_i != 5'd0);
            end
         end
         StWait: begin
            stall_o = ~mem_ack_i;
            if (mem_ack_i) begin
               state_d = StIdle;
               cnt_d   = '0;
               if (!wr_q) begin
                  rd_d     = load_val;
                  rd_ptr_d = ld_ptr_q;
                  reg_we_d = ld_we_q;
               end
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               // Abort: release upstream this cycle, report the error next cycle.
               state_d   = StIdle;
               cnt_d     = '0;
               bus_err_d = 1'b1;
               stall_o   = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         wr_q       <= 1'b0;
         hb_q       <= '0;
         ul_q       <= 1'b0;
         ld_ptr_q   <= '0;
         ld_we_q    <= 1'b0;
         rd_q       <= '0;
         rd_ptr_q   <= '0;
         reg_we_q   <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         wr_q       <= wr_d;
         hb_q       <= hb_d;
         ul_q       <= ul_d;
         ld_ptr_q   <= ld_ptr_d;
         ld_we_q    <= ld_we_d;
         rd_q       <= rd_d;
         rd_ptr_q   <= rd_ptr_d;
         reg_we_q   <= reg_we_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign mem_req_o   = (state_q == StWait);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
   assign mem_wr_o    = wr_q;
   assign rd_o        = rd_q;
   assign rd_ptr_o    = rd_ptr_q;
   assign reg_we_o    = reg_we_q;
   assign misalign_o  = misalign_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_execute_mem_stage.sv
// Directed bench for execute_mem_stage: ALU vector table plus load/store, misalign,
// timeout and reset-during-access sequences.
module tb_execute_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] rs1_i, rs2_i, imm_i;
   logic [4:0]  rd_ptr_i;
   logic [7:0]  funct3I_i;
   logic [6:0]  funct7_i;
   logic        alu_src_i, reg_we_i, mem_we_i, mem_re_i, ul_i;
   logic [1:0]  hb_i;
   logic        stall_o, mem_req_o, mem_wr_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, rd_o;
   logic [3:0]  mem_be_o;
   logic [4:0]  rd_ptr_o;
   logic        reg_we_o, misalign_o, bus_err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   execute_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
      .rd_ptr_i(rd_ptr_i), .funct3I_i(funct3I_i), .funct7_i(funct7_i),
      .alu_src_i(alu_src_i), .reg_we_i(reg_we_i), .mem_we_i(mem_we_i),
      .mem_re_i(mem_re_i), .hb_i(hb_i), .ul_i(ul_i), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_wr_o(mem_wr_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .rd_o(rd_o), .rd_ptr_o(rd_ptr_o), .reg_we_o(reg_we_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   typedef struct {
      logic [31:0] rs1, rs2, imm;
      logic [4:0]  rd;
      logic [7:0]  f3;
      logic [6:0]  f7;
      logic        src, we;
      logic [31:0] exp_rd;
      logic        exp_we;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [7:0] f3,
                         input logic [6:0] f7, input logic src, input logic we,
                         input logic mwe, input logic mre, input logic [1:0] hb,
                         input logic ul);
      rs1_i = rs1; rs2_i = rs2; imm_i = imm; rd_ptr_i = rd; funct3I_i = f3;
      funct7_i = f7; alu_src_i = src; reg_we_i = we; mem_we_i = mwe; mem_re_i = mre;
      hb_i = hb; ul_i = ul;
   endtask

   task automatic nop();
      set_op(32'd0, 32'd0, 32'd0, 5'd0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   // Byte load from 0x103; ack arrives in the 4th WAIT cycle (last one before timeout).
   task automatic run_lb(input logic ul, input logic [31:0] exp);
      set_op(32'h100, 32'd0, 32'd3, 5'd5, 8'h01, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, ul);
      #1;
      chk("lb_idle_stall", {31'd0, stall_o}, 32'd1);
      chk("lb_idle_req", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("lb_req", {31'd0, mem_req_o}, 32'd1);
      chk("lb_addr", mem_addr_o, 32'h103);
      chk("lb_be", {28'd0, mem_be_o}, 32'b1000);
      chk("lb_wr", {31'd0, mem_wr_o}, 32'd0);
      chk("lb_we_wait", {31'd0, reg_we_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("lb_wait_stall", {31'd0, stall_o}, 32'd1);
         tick();
      end
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h80AABBCC;
      #1;
      chk("lb_ack_stall", {31'd0, stall_o}, 32'd0);
      chk("lb_ack_req", {31'd0, mem_req_o}, 32'd1);
      tick();
      mem_ack_i = 1'b0;
      nop();
      chk("lb_rd", rd_o, exp);
      chk("lb_rd_ptr", {27'd0, rd_ptr_o}, 32'd5);
      chk("lb_we", {31'd0, reg_we_o}, 32'd1);
      chk("lb_req_done", {31'd0, mem_req_o}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h7FFFFFFF, 32'd1, 32'd0, 5'd1, 8'h01, 7'h00, 1'b0, 1'b1, 32'h80000000, 1'b1};
      vecs[1]  = '{32'h7FFFFFFF, 32'd1, 32'd0, 5'd1, 8'h01, 7'h20, 1'b0, 1'b1, 32'h7FFFFFFE, 1'b1};
      vecs[2]  = '{32'h80000010, 32'd4, 32'd0, 5'd2, 8'h20, 7'h20, 1'b0, 1'b1, 32'hF8000001, 1'b1};
      vecs[3]  = '{32'h80000010, 32'd4, 32'd0, 5'd2, 8'h20, 7'h00, 1'b0, 1'b1, 32'h08000001, 1'b1};
      vecs[4]  = '{32'd1, 32'hFFFFFFFF, 32'd0, 5'd0, 8'h08, 7'h00, 1'b0, 1'b1, 32'd1, 1'b0};
      vecs[5]  = '{32'd1, 32'hFFFFFFFF, 32'd0, 5'd3, 8'h04, 7'h00, 1'b0, 1'b1, 32'd0, 1'b1};
      vecs[6]  = '{32'd1, 32'd0, 32'h23, 5'd4, 8'h02, 7'h00, 1'b1, 1'b1, 32'd8, 1'b1};
      vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd6, 8'h10, 7'h00, 1'b0, 1'b1, 32'h0FF00FF0, 1'b1};
      vecs[8]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd7, 8'h40, 7'h00, 1'b0, 1'b1, 32'hFFF0FFF0, 1'b1};
      vecs[9]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd8, 8'h80, 7'h00, 1'b0, 1'b1, 32'hF000F000, 1'b1};
      vecs[10] = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd9, 8'h03, 7'h00, 1'b0, 1'b1, 32'd0, 1'b1};
      vecs[11] = '{32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd9, 8'h00, 7'h00, 1'b0, 1'b1, 32'd0, 1'b1};
      vecs[12] = '{32'h100, 32'd0, 32'hFFFFFFFF, 5'd31, 8'h01, 7'h00, 1'b1, 1'b1, 32'h000000FF, 1'b1};
      vecs[13] = '{32'd5, 32'd6, 32'd0, 5'd10, 8'h01, 7'h00, 1'b0, 1'b0, 32'd11, 1'b0};

      rst_ni = 1'b0;
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      nop();
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rst_rd", rd_o, 32'd0);
      chk("rst_flags", {24'd0, reg_we_o, stall_o, mem_req_o, mem_wr_o, misalign_o,
                        bus_err_o, 2'b00}, 32'd0);
      chk("rst_bus", mem_addr_o | mem_wdata_o | {28'd0, mem_be_o} | {27'd0, rd_ptr_o}, 32'd0);

      for (int i = 0; i < 14; i++) begin
         set_op(vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd, vecs[i].f3, vecs[i].f7,
                vecs[i].src, vecs[i].we, 1'b0, 1'b0, 2'b00, 1'b0);
         #1;
         chk($sformatf("alu%0d_stall", i), {31'd0, stall_o}, 32'd0);
         tick();
         chk($sformatf("alu%0d_rd", i), rd_o, vecs[i].exp_rd);
         chk($sformatf("alu%0d_ptr", i), {27'd0, rd_ptr_o}, {27'd0, vecs[i].rd});
         chk($sformatf("alu%0d_we", i), {31'd0, reg_we_o}, {31'd0, vecs[i].exp_we});
         chk($sformatf("alu%0d_req", i), {31'd0, mem_req_o}, 32'd0);
      end

      run_lb(1'b0, 32'hFFFFFF80);
      run_lb(1'b1, 32'h00000080);

      // Half store to 0x102, acked in the first WAIT cycle.
      set_op(32'h100, 32'h1234ABCD, 32'd2, 5'd7, 8'h01, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0,
             2'b01, 1'b0);
      tick();
      chk("sh_req", {31'd0, mem_req_o}, 32'd1);
      chk("sh_be", {28'd0, mem_be_o}, 32'b1100);
      chk("sh_wdata", mem_wdata_o, 32'hABCDABCD);
      chk("sh_wr", {31'd0, mem_wr_o}, 32'd1);
      chk("sh_addr", mem_addr_o, 32'h102);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      nop();
      chk("sh_we", {31'd0, reg_we_o}, 32'd0);
      chk("sh_req_done", {31'd0, mem_req_o}, 32'd0);

      // Misaligned word load.
      set_op(32'h100, 32'd0, 32'd1, 5'd8, 8'h01, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      #1;
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      tick();
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      chk("mis_req", {31'd0, mem_req_o}, 32'd0);
      chk("mis_we", {31'd0, reg_we_o}, 32'd0);
      nop();
      tick();
      chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
      chk("mis_req_after", {31'd0, mem_req_o}, 32'd0);

      // Word load with no ack: aborts after 4 WAIT cycles.
      set_op(32'h100, 32'd0, 32'd0, 5'd9, 8'h01, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("to_stall", {31'd0, stall_o}, 32'd1);
         chk("to_req", {31'd0, mem_req_o}, 32'd1);
         tick();
      end
      chk("to_last_stall", {31'd0, stall_o}, 32'd0);
      chk("to_last_req", {31'd0, mem_req_o}, 32'd1);
      chk("to_no_err_yet", {31'd0, bus_err_o}, 32'd0);
      tick();
      nop();
      chk("to_err", {31'd0, bus_err_o}, 32'd1);
      chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("to_we", {31'd0, reg_we_o}, 32'd0);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      chk("to_err_end", {31'd0, bus_err_o}, 32'd0);
      chk("late_ack_we", {31'd0, reg_we_o}, 32'd0);

      // Reset while WAIT.
      set_op(32'h104, 32'd0, 32'd0, 5'd11, 8'h01, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      tick();
      chk("rw_req", {31'd0, mem_req_o}, 32'd1);
      rst_ni = 1'b0;
      nop();
      tick();
      rst_ni = 1'b1;
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hDEADBEEF;
      #1;
      chk("rw_req_low", {31'd0, mem_req_o}, 32'd0);
      chk("rw_stall_low", {31'd0, stall_o}, 32'd0);
      chk("rw_outs", mem_addr_o | rd_o | {28'd0, mem_be_o}, 32'd0);
      tick();
      mem_ack_i = 1'b0;
      chk("rw_ack_ignored_we", {31'd0, reg_we_o}, 32'd0);
      chk("rw_ack_ignored_rd", rd_o, 32'd0);
      chk("rw_ack_ignored_req", {31'd0, mem_req_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
